// File: rtl/keypad_matrix_scanner_if.sv
// keypad_matrix_scanner_if
// Bundles the keypad matrix wiring and the debounced coordinate output.
//   key_col     : one-hot column drive, active-high (scanner -> matrix)
//   key_line    : line sense, active-high, asynchronous (matrix -> scanner)
//   coord_out   : {column code 1..NCOL, line code 1..NLINE} of the accepted key
//   coord_valid : one-cycle strobe qualifying coord_out
//   key_held    : high while a key is accepted as held
// master = the scanner, slave = the matrix/consumer side.
// NCOL/NLINE must match the parameters of the scanner instance.
interface keypad_matrix_scanner_if #(
    parameter int NCOL  = 5,
    parameter int NLINE = 7
);
    logic [NCOL-1:0]  key_col;
    logic [NLINE-1:0] key_line;
    logic [5:0]       coord_out;
    logic             coord_valid;
    logic             key_held;

    modport master (
        output key_col,
        output coord_out,
        output coord_valid,
        output key_held,
        input  key_line
    );

    modport slave (
        input  key_col,
        input  coord_out,
        input  coord_valid,
        input  key_held,
        output key_line
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans an NCOL x NLINE push-button matrix one column at a time, debounces a
// single pressed key over whole scan frames and emits a one-cycle strobe with
// the 6-bit {column code, line code} coordinate of the accepted key.
//   clk : scan clock
//   clr : synchronous active-high reset
//   bus : keypad_matrix_scanner_if.master (key_col, key_line, coord_out,
//         coord_valid, key_held)
module keypad_matrix_scanner #(
    parameter int NCOL       = 5,
    parameter int NLINE      = 7,
    parameter int SCAN_DIV   = 4,
    parameter int DEB_FRAMES = 3
) (
    input  logic                            clk,
    input  logic                            clr,
    keypad_matrix_scanner_if.master         bus
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int NW = $clog2(DEB_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [2:0]    COL_LAST   = 3'(NCOL - 1);
    localparam logic [NW-1:0] DEB_LAST   = NW'(DEB_FRAMES);
    localparam logic [NW-1:0] CNT_ONE    = NW'(1);
    localparam logic [NCOL-1:0] COL_FIRST = {{(NCOL-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    function automatic logic [2:0] popcount(input logic [NLINE-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NLINE; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Walks downward so the lowest set line wins.
    function automatic logic [2:0] lowest_index(input logic [NLINE-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NLINE - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [NLINE-1:0] sync1_r, sync2_r;
    logic [DW-1:0]    dwell_r;
    logic [2:0]       col_r;
    logic [NCOL-1:0]  key_col_r;
    logic [1:0]       acc_cnt_r;
    logic [2:0]       acc_col_r, acc_line_r;
    state_t           state_r, state_s;
    logic [NW-1:0]    cnt_r, cnt_s;
    logic [5:0]       cand_r, cand_s;
    logic [5:0]       coord_r, coord_s;
    logic             valid_r, valid_s;
    logic             held_r, held_s;

    logic             sample_s, frame_end_s, hit_s;
    logic [3:0]       sum_s;
    logic [1:0]       frm_cnt_s;
    logic [2:0]       frm_col_s, frm_line_s;
    logic [5:0]       frm_coord_s;
    logic [NW-1:0]    cnt_inc_s;

    assign sample_s    = (dwell_r == DWELL_LAST);
    assign frame_end_s = sample_s && (col_r == COL_LAST);

    // Two-flop synchronizer for the asynchronous line inputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= bus.key_line;
            sync2_r <= sync1_r;
        end
    end

    // Dwell counter and column walker; the drive changes when dwell returns to 0.
    always_ff @(posedge clk) begin
        if (clr) begin
            dwell_r   <= '0;
            col_r     <= 3'd0;
            key_col_r <= COL_FIRST;
        end else if (sample_s) begin
            dwell_r <= '0;
            if (col_r == COL_LAST) begin
                col_r     <= 3'd0;
                key_col_r <= COL_FIRST;
            end else begin
                col_r     <= col_r + 3'd1;
                key_col_r <= key_col_r << 1;
            end
        end else begin
            dwell_r <= dwell_r + DW'(1);
        end
    end

    // Frame summary including the column being sampled right now, so the
    // frame-end decision sees the last column without an extra cycle.
    always_comb begin
        hit_s       = (sync2_r != '0);
        sum_s       = {2'b00, acc_cnt_r} + {1'b0, popcount(sync2_r)};
        frm_cnt_s   = !hit_s ? acc_cnt_r : ((sum_s >= 4'd2) ? 2'd2 : sum_s[1:0]);
        frm_col_s   = hit_s ? col_r : acc_col_r;
        frm_line_s  = hit_s ? lowest_index(sync2_r) : acc_line_r;
        frm_coord_s = {frm_col_s + 3'd1, frm_line_s + 3'd1};
    end

    // Frame accumulator: updated at each sample, cleared at frame end.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc_cnt_r  <= 2'd0;
            acc_col_r  <= 3'd0;
            acc_line_r <= 3'd0;
        end else if (frame_end_s) begin
            acc_cnt_r  <= 2'd0;
            acc_col_r  <= 3'd0;
            acc_line_r <= 3'd0;
        end else if (sample_s) begin
            acc_cnt_r  <= frm_cnt_s;
            acc_col_r  <= frm_col_s;
            acc_line_r <= frm_line_s;
        end else begin
            acc_cnt_r  <= acc_cnt_r;
            acc_col_r  <= acc_col_r;
            acc_line_r <= acc_line_r;
        end
    end

    // Debounce state machine: next state and registered-output values.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        cand_s    = cand_r;
        coord_s   = coord_r;
        valid_s   = 1'b0;
        cnt_inc_s = cnt_r + CNT_ONE;
        if (frame_end_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (frm_cnt_s == 2'd1) begin
                        cand_s = frm_coord_s;
                        cnt_s  = CNT_ONE;
                        if (DEB_LAST == CNT_ONE) begin
                            state_s = ST_PRESSED;
                            coord_s = frm_coord_s;
                            valid_s = 1'b1;
                        end else begin
                            state_s = ST_DEBOUNCE;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (frm_cnt_s == 2'd1) begin
                        if (frm_coord_s == cand_r) begin
                            cnt_s = cnt_inc_s;
                            if (cnt_inc_s == DEB_LAST) begin
                                state_s = ST_PRESSED;
                                coord_s = cand_r;
                                valid_s = 1'b1;
                            end else begin
                                state_s = ST_DEBOUNCE;
                            end
                        end else begin
                            cand_s = frm_coord_s;
                            cnt_s  = CNT_ONE;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (frm_cnt_s == 2'd0) begin
                        cnt_s = CNT_ONE;
                        if (DEB_LAST == CNT_ONE) begin
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        state_s = ST_PRESSED;
                    end
                end
                ST_RELEASE: begin
                    if (frm_cnt_s == 2'd0) begin
                        cnt_s = cnt_inc_s;
                        if (cnt_inc_s == DEB_LAST) begin
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        state_s = ST_PRESSED;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
        held_s = (state_s == ST_PRESSED) || (state_s == ST_RELEASE);
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            cand_r  <= 6'd0;
            coord_r <= 6'd0;
            valid_r <= 1'b0;
            held_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            cand_r  <= cand_s;
            coord_r <= coord_s;
            valid_r <= valid_s;
            held_r  <= held_s;
        end
    end

    assign bus.key_col     = key_col_r;
    assign bus.coord_out   = coord_r;
    assign bus.coord_valid = valid_r;
    assign bus.key_held    = held_r;
endmodule
